uart_rx_sampler: RTL and testbench

- Standalone 8N1 UART receive front-end.
- Oversamples the serial line, majority-votes each bit, and checks framing.
- Presents received bytes through a one-entry holding register with a valid/ready handshake.
- Sits between the board RXD pin and the receive FIFO of the UART controller; it is the receiving end of the existing serial transmitter.

---
 rtl/uart_rx_sampler.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//
// 8N1 UART receive front-end. The asynchronous rxd line is synchronised and
// then oversampled. Each bit is decided by a 3-sample majority vote around
// the bit centre, and the stop bit is checked for framing. Received bytes go
// into a one-entry holding register that the consumer drains with a
// valid/ready handshake.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   rxd            asynchronous serial input, idle high
//   data[7:0]      received byte, meaningful while data_valid=1
//   data_valid     holding register full
//   data_ready     consumer accepts data when data_valid & data_ready
//   frame_error    one-cycle pulse: stop bit sampled low
//   overrun        sticky: a byte was dropped because the holding register
//                  was full
//   overrun_clear  clears overrun; takes priority over a simultaneous set
//   idle           receiver in IDLE and synchronised rxd high
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
  parameter int ClkFrequency = 60_000_000,
  parameter int Baud         = 115200,
  parameter int Oversample   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_error,
  output logic       overrun,
  input  logic       overrun_clear,
  output logic       idle
);

  // Clocks per oversample tick, rounded to nearest.
  localparam int DIV = (ClkFrequency + Baud * Oversample / 2) / (Baud * Oversample);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(Oversample);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_VOTE0  = SW'(Oversample / 2 - 1);
  localparam logic [SW-1:0] S_VOTE1  = SW'(Oversample / 2);
  localparam logic [SW-1:0] S_VOTE2  = SW'(Oversample / 2 + 1);
  localparam logic [SW-1:0] S_LAST   = SW'(Oversample - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic [1:0]    sync_reg;
  logic          rxd_s;
  logic [2:0]    state_reg;
  logic [DW-1:0] div_reg;
  logic [SW-1:0] s_reg;
  logic [2:0]    bit_idx_reg;
  logic [1:0]    samp_reg;
  logic [7:0]    shift_reg;
  logic          commit_pend_reg;
  logic          stop_vote_reg;
  logic [7:0]    data_reg;
  logic          data_valid_reg;
  logic          frame_error_reg;
  logic          overrun_reg;

  logic tick;
  logic vote;
  logic vote_tick;
  logic last_tick;
  logic handshake;
  logic commit;

  assign rxd_s = sync_reg[1];

  // The divider is frozen at 0 in IDLE, so the first tick of a frame lands
  // exactly DIV clocks after the start edge is seen.
  assign tick      = (state_reg != ST_IDLE) && (div_reg == DIV_LAST);
  assign vote_tick = tick && (s_reg == S_VOTE2);
  assign last_tick = tick && (s_reg == S_LAST);

  // Majority of the two stored samples and the live third sample.
  assign vote = (samp_reg[0] & samp_reg[1]) |
                (samp_reg[0] & rxd_s) |
                (samp_reg[1] & rxd_s);

  assign handshake = data_valid_reg & data_ready;
  assign commit    = commit_pend_reg & stop_vote_reg;

  // -------------------------------------------------------------------------
  // Synchroniser, tick divider, sample counter and frame FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg        <= 2'b11;
      state_reg       <= ST_IDLE;
      div_reg         <= '0;
      s_reg           <= '0;
      bit_idx_reg     <= 3'd0;
      samp_reg        <= 2'b11;
      shift_reg       <= 8'h00;
      commit_pend_reg <= 1'b0;
      stop_vote_reg   <= 1'b0;
    end else begin
      sync_reg        <= {sync_reg[0], rxd};
      commit_pend_reg <= 1'b0;

      if (state_reg == ST_IDLE || tick) begin
        div_reg <= '0;
      end else begin
        div_reg <= div_reg + DW'(1);
      end

      if (state_reg == ST_IDLE) begin
        s_reg <= '0;
      end else if (tick) begin
        s_reg <= (s_reg == S_LAST) ? '0 : s_reg + SW'(1);
      end

      if (tick && s_reg == S_VOTE0) samp_reg[0] <= rxd_s;
      if (tick && s_reg == S_VOTE1) samp_reg[1] <= rxd_s;

      case (state_reg)
        ST_IDLE: begin
          bit_idx_reg <= 3'd0;
          if (!rxd_s) state_reg <= ST_START;
        end
        ST_START: begin
          // A start bit that votes high was only a glitch.
          if (vote_tick && vote) begin
            state_reg <= ST_IDLE;
          end else if (last_tick) begin
            state_reg   <= ST_DATA;
            bit_idx_reg <= 3'd0;
          end
        end
        ST_DATA: begin
          if (vote_tick) shift_reg <= {vote, shift_reg[7:1]};
          if (last_tick) begin
            if (bit_idx_reg == 3'd7) begin
              state_reg <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end
        end
        ST_STOP: begin
          // Decide at the stop-bit centre rather than its end so a following
          // start edge is never missed on back-to-back frames.
          if (vote_tick) begin
            commit_pend_reg <= 1'b1;
            stop_vote_reg   <= vote;
          end
          if (commit_pend_reg) begin
            state_reg <= stop_vote_reg ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (rxd_s) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Holding register, overrun and frame error
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg        <= 8'h00;
      data_valid_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      frame_error_reg <= commit_pend_reg & ~stop_vote_reg;

      // A byte may replace the held one only if that one leaves this cycle.
      if (commit && (!data_valid_reg || handshake)) begin
        data_reg       <= shift_reg;
        data_valid_reg <= 1'b1;
      end else if (handshake) begin
        data_valid_reg <= 1'b0;
      end

      if (overrun_clear) begin
        overrun_reg <= 1'b0;
      end else if (commit && data_valid_reg && !handshake) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign data        = data_reg;
  assign data_valid  = data_valid_reg;
  assign frame_error = frame_error_reg;
  assign overrun     = overrun_reg;
  assign idle        = (state_reg == ST_IDLE) && rxd_s;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_sampler
//
// Drives 8N1 frames into uart_rx_sampler and checks the received bytes,
// handshakes, framing errors and overrun behaviour. The receiver runs with a
// reduced clock (4 clocks per oversample tick, 64 clocks per bit) so that a
// large number of frames fit in a short run; all timing expectations are
// derived from the same parameters.
// ---------------------------------------------------------------------------
module tb_uart_rx_sampler;

  localparam int CLK_HZ    = 7_372_800;
  localparam int BAUD      = 115200;
  localparam int OVS       = 16;
  localparam int DIV       = (CLK_HZ + BAUD * OVS / 2) / (BAUD * OVS);
  localparam int BIT_CLKS  = DIV * OVS;
  localparam int LAT_TICKS = (1 + 8) * OVS + 10;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       frame_error;
  logic       overrun;
  logic       overrun_clear;
  logic       idle;

  uart_rx_sampler #(
    .ClkFrequency(CLK_HZ),
    .Baud        (BAUD),
    .Oversample  (OVS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .overrun_clear(overrun_clear),
    .idle         (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] hs_q[$];
  int fe_cycles = 0;

  // Bus monitor: records each accepted byte and every cycle frame_error is
  // high (a correct pulse is exactly one cycle per bad frame).
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid && data_ready) begin
        hs_q.push_back(data);
        $display("handshake data=%02h", data);
      end
      if (frame_error) fe_cycles++;
    end
  end

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: start bit, 8 data bits LSB first, then either one high stop
  // bit or stop_low bit periods of low followed by one bit period high.
  task automatic send_frame(input logic [7:0] b, input int bclk, input int stop_low);
    rxd = 1'b0;
    step(bclk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      step(bclk);
    end
    if (stop_low > 0) begin
      rxd = 1'b0;
      step(bclk * stop_low);
    end
    rxd = 1'b1;
    step(bclk);
  endtask

  task automatic consume(input string name, input logic [7:0] exp);
    hs_q.delete();
    data_ready = 1'b1;
    step(1);
    data_ready = 1'b0;
    step(1);
    chk({name, "_hs_count"}, hs_q.size(), 1);
    if (hs_q.size() > 0) chk({name, "_hs_data"}, hs_q[0], exp);
    chk({name, "_valid_cleared"}, data_valid, 0);
  endtask

  typedef struct {
    logic [7:0] byte_in;
    int         stop_low;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int fe0;
    logic [7:0] exp_q[$];
    int n_bad;

    vecs[0] = '{8'h00, 0, 1'b1, 8'h00, 0};
    vecs[1] = '{8'hFF, 0, 1'b1, 8'hFF, 0};
    vecs[2] = '{8'h81, 2, 1'b0, 8'hFF, 1};  // long break: byte discarded
    vecs[3] = '{8'h42, 0, 1'b1, 8'h42, 0};
    vecs[4] = '{8'h5A, 0, 1'b1, 8'h5A, 0};
    vecs[5] = '{8'h0F, 1, 1'b0, 8'h5A, 1};

    rst_n         = 1'b0;
    rxd           = 1'b1;
    data_ready    = 1'b0;
    overrun_clear = 1'b0;
    step(3);
    chk("reset_data", data, 8'h00);
    chk("reset_valid", data_valid, 0);
    chk("reset_frame_error", frame_error, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_idle", idle, 1);
    rst_n = 1'b1;
    step(5);

    // First frame with latency measurement from the start edge.
    fe0 = fe_cycles;
    lat = 0;
    fork
      send_frame(8'hA5, BIT_CLKS, 0);
      begin
        while (!data_valid && lat < 12 * BIT_CLKS) begin
          step(1);
          lat++;
        end
      end
    join
    $display("frame A5 latency=%0d clk data=%02h valid=%0b", lat, data, data_valid);
    chk("a5_latency_window", int'(lat >= LAT_TICKS * DIV + 2 && lat <= LAT_TICKS * DIV + 5), 1);
    chk("a5_data", data, 8'hA5);
    chk("a5_valid", data_valid, 1);
    chk("a5_no_frame_error", fe_cycles - fe0, 0);
    chk("a5_idle", idle, 1);
    consume("a5", 8'hA5);

    // Table of single frames, each left unconsumed until checked.
    for (int v = 0; v < 6; v++) begin
      fe0 = fe_cycles;
      send_frame(vecs[v].byte_in, BIT_CLKS, vecs[v].stop_low);
      $display("vec %0d byte=%02h stop_low=%0d data=%02h valid=%0b fe=%0d", v,
               vecs[v].byte_in, vecs[v].stop_low, data, data_valid, fe_cycles - fe0);
      chk($sformatf("vec%0d_valid", v), data_valid, vecs[v].exp_valid);
      chk($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
      chk($sformatf("vec%0d_frame_error", v), fe_cycles - fe0, vecs[v].exp_fe);
      chk($sformatf("vec%0d_idle", v), idle, 1);
      if (vecs[v].exp_valid) consume($sformatf("vec%0d", v), vecs[v].exp_data);
    end

    // Back-to-back frames with the consumer always ready.
    hs_q.delete();
    data_ready = 1'b1;
    send_frame(8'h00, BIT_CLKS, 0);
    send_frame(8'hFF, BIT_CLKS, 0);
    send_frame(8'h55, BIT_CLKS, 0);
    step(2);
    data_ready = 1'b0;
    $display("b2b handshakes=%0d overrun=%0b", hs_q.size(), overrun);
    chk("b2b_count", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      chk("b2b_first", hs_q[0], 8'h00);
      chk("b2b_second", hs_q[1], 8'hFF);
      chk("b2b_third", hs_q[2], 8'h55);
    end
    chk("b2b_overrun", overrun, 0);

    // Overrun: second byte dropped while the first is still held.
    send_frame(8'h3C, BIT_CLKS, 0);
    send_frame(8'hC3, BIT_CLKS, 0);
    $display("overrun data=%02h valid=%0b overrun=%0b", data, data_valid, overrun);
    chk("ovr_data_kept", data, 8'h3C);
    chk("ovr_valid", data_valid, 1);
    chk("ovr_set", overrun, 1);
    overrun_clear = 1'b1;
    step(1);
    overrun_clear = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // Consumer accepts the old byte in the very cycle the new one commits.
    hs_q.delete();
    fork
      send_frame(8'h77, BIT_CLKS, 0);
      begin
        step(3 + LAT_TICKS * DIV);
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
      end
    join
    $display("same-cycle commit data=%02h valid=%0b overrun=%0b", data, data_valid, overrun);
    chk("same_cycle_data", data, 8'h77);
    chk("same_cycle_valid", data_valid, 1);
    chk("same_cycle_overrun", overrun, 0);
    chk("same_cycle_hs_count", hs_q.size(), 1);
    if (hs_q.size() > 0) chk("same_cycle_hs_old", hs_q[0], 8'h3C);

    // overrun_clear held while a byte is dropped: overrun must stay low.
    overrun_clear = 1'b1;
    send_frame(8'h11, BIT_CLKS, 0);
    overrun_clear = 1'b0;
    step(1);
    $display("clear-wins data=%02h overrun=%0b", data, overrun);
    chk("clear_wins_data", data, 8'h77);
    chk("clear_wins_overrun", overrun, 0);
    consume("after_77", 8'h77);

    // Short low glitch of three ticks on an idle line.
    fe0 = fe_cycles;
    rxd = 1'b0;
    step(3 * DIV);
    rxd = 1'b1;
    step(2 * BIT_CLKS);
    $display("glitch valid=%0b fe=%0d idle=%0b", data_valid, fe_cycles - fe0, idle);
    chk("glitch_valid", data_valid, 0);
    chk("glitch_frame_error", fe_cycles - fe0, 0);
    chk("glitch_idle", idle, 1);

    // Reset in the middle of a frame with a full holding register and overrun.
    send_frame(8'h6E, BIT_CLKS, 0);
    send_frame(8'h6F, BIT_CLKS, 0);
    chk("pre_reset_overrun", overrun, 1);
    rxd = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rxd = (i % 2 == 0) ? 1'b1 : 1'b0;  // 0xF5 low nibble, LSB first
      step(BIT_CLKS);
    end
    rxd = 1'b1;  // bit 4 onwards of 0xF5 are all high
    step(BIT_CLKS / 2);
    rst_n = 1'b0;
    #1;
    $display("midframe reset data=%02h valid=%0b overrun=%0b idle=%0b", data, data_valid, overrun, idle);
    chk("midrst_data", data, 8'h00);
    chk("midrst_valid", data_valid, 0);
    chk("midrst_frame_error", frame_error, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_idle", idle, 1);
    step(2);
    rst_n = 1'b1;
    step(5 * BIT_CLKS);
    chk("midrst_no_output", data_valid, 0);
    send_frame(8'h99, BIT_CLKS, 0);
    $display("frame 99 data=%02h valid=%0b", data, data_valid);
    chk("after_reset_data", data, 8'h99);
    chk("after_reset_valid", data_valid, 1);
    consume("after_reset", 8'h99);

    // Random frames with baud skew, random gaps and some bad stop bits.
    // Expected result: every frame with a good stop bit is delivered in order,
    // every bad one produces exactly one frame_error cycle.
    hs_q.delete();
    exp_q.delete();
    n_bad = 0;
    fe0 = fe_cycles;
    data_ready = 1'b1;
    for (int f = 0; f < 16; f++) begin
      logic [7:0] b;
      int bclk;
      int bad;
      b    = 8'($urandom_range(0, 255));
      bclk = int'($urandom_range(BIT_CLKS - 2, BIT_CLKS + 2));
      bad  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      $display("rand %0d byte=%02h bit_clks=%0d stop_low=%0d", f, b, bclk, bad);
      send_frame(b, bclk, bad);
      if (bad == 0) exp_q.push_back(b);
      else n_bad++;
      step(int'($urandom_range(2, BIT_CLKS)));
    end
    step(BIT_CLKS);
    data_ready = 1'b0;
    chk("rand_count", hs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
      chk($sformatf("rand_byte%0d", i), hs_q[i], exp_q[i]);
    end
    chk("rand_frame_errors", fe_cycles - fe0, n_bad);
    chk("rand_overrun", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
